// File: rtl/irq_controller.sv
// irq_controller: synchronises raw peripheral request lines, latches rising
// edges into PENDING, and presents the lowest-index enabled request to the
// core as a one-hot cpu_int with a matching int_id, handshaken by ack/eret.
module irq_controller #(
  parameter int NUM_IRQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               bus_we,
  input  logic [1:0]         bus_addr,
  input  logic [31:0]        bus_wdata,
  output logic [31:0]        bus_rdata,
  output logic [NUM_IRQ-1:0] cpu_int,
  output logic [ID_W-1:0]    int_id,
  input  logic               cpu_ack,
  input  logic               cpu_eret
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_e;

  logic [NUM_IRQ-1:0] sync1_q, sync2_q, hist_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d, mask_q, mask_d;
  logic [NUM_IRQ-1:0] int_q, int_d;
  logic [ID_W-1:0]    id_q, id_d;
  state_e             state_q, state_d;

  logic [NUM_IRQ-1:0] edge_w, w1c_w, keep_w, ack_clr, pm_w;
  logic [ID_W-1:0]    win_id;
  logic               win_vld;
  logic               unused_wdata;

  assign unused_wdata = ^bus_wdata[31:NUM_IRQ];

  // Two-flop synchroniser plus history flop; edge fires once per low->high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign edge_w = sync2_q & ~hist_q;
  assign w1c_w  = (bus_we && bus_addr == 2'd0) ? bus_wdata[NUM_IRQ-1:0] : '0;
  assign mask_d = (bus_we && bus_addr == 2'd1) ? bus_wdata[NUM_IRQ-1:0] : mask_q;
  // What PENDING would hold this edge ignoring the ack clear; set beats W1C.
  assign keep_w = (pend_q & ~w1c_w) | edge_w;
  assign pm_w   = pend_q & mask_q;

  // Lowest-index enabled pending request wins.
  always_comb begin
    win_id  = '0;
    win_vld = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pm_w[i]) begin
        win_id  = ID_W'(i);
        win_vld = 1'b1;
      end
    end
  end

  // Next-state logic; cpu_int is registered so it tracks the state register.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    int_d   = '0;
    ack_clr = '0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          id_d    = win_id;
          state_d = ASSERT;
          int_d   = NUM_IRQ'(1) << win_id;
        end
      end
      ASSERT: begin
        // A mask or W1C landing this cycle withdraws the request before ack.
        if (!(keep_w[id_q] && mask_d[id_q])) begin
          state_d = IDLE;
        end else if (cpu_ack) begin
          ack_clr[id_q] = 1'b1;
          state_d       = SERVICE;
        end else begin
          int_d = NUM_IRQ'(1) << id_q;
        end
      end
      SERVICE: begin
        if (cpu_eret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Edge set has priority over both W1C and the ack clear.
  assign pend_d = (pend_q & ~w1c_w & ~ack_clr) | edge_w;

  // Register state, pending, mask and the presented request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      int_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      int_q   <= int_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
    end
  end

  assign cpu_int = int_q;
  assign int_id  = id_q;

  // Combinational register read window.
  always_comb begin
    bus_rdata = '0;
    case (bus_addr)
      2'd0: bus_rdata[NUM_IRQ-1:0] = pend_q;
      2'd1: bus_rdata[NUM_IRQ-1:0] = mask_q;
      2'd2: begin
        bus_rdata[9:8]    = state_q;
        bus_rdata[ID_W-1:0] = id_q;
      end
      default: bus_rdata = '0;
    endcase
  end

endmodule
